// File: rtl/cpu_fetch.sv
// cpu_fetch: one/two-byte instruction fetch with valid/ready hand-off to decode and jump redirect.
// Optional retired-instruction counter (instr_count port) enabled by defining CPU_FETCH_COUNT_EN.
module cpu_fetch (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  pc_addr,
    output logic        increment,
    output logic        jumper,
    output logic [7:0]  jumper_d,
    output logic        mem_req,
    output logic [7:0]  mem_addr,
    input  logic        mem_ready,
    input  logic [7:0]  mem_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [7:0]  ir_op,
    output logic [7:0]  ir_arg,
    input  logic        jump_req,
`ifdef CPU_FETCH_COUNT_EN
    input  logic [7:0]  jump_target,
    output logic [15:0] instr_count
`else
    input  logic [7:0]  jump_target
`endif
);
    typedef enum logic [1:0] {FETCH_OP, FETCH_ARG, HOLD} state_t;
    state_t state, state_nxt;
    logic accept, retire;
    // PC/memory controls and next state; a redirect overrides any fetch or hand-off this cycle
    always_comb begin
        mem_req   = (state != HOLD) & ~jump_req & ~reset;
        accept    = mem_req & mem_ready;
        retire    = (state == HOLD) & instr_valid & instr_ready & ~jump_req;
        increment = accept;
        jumper    = jump_req & ~reset;
        jumper_d  = jumper ? jump_target : 8'h00;
        mem_addr  = pc_addr;
        state_nxt = state;
        if (jump_req)
            state_nxt = FETCH_OP;
        else if (accept)
            state_nxt = (state == FETCH_OP && mem_data[7]) ? FETCH_ARG : HOLD;
        else if (retire)
            state_nxt = FETCH_OP;
    end
    // State and instruction register; ir_op/ir_arg keep their value across a redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH_OP;
            ir_op       <= 8'h00;
            ir_arg      <= 8'h00;
            instr_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept && state == FETCH_OP) begin
                ir_op <= mem_data;
                if (!mem_data[7]) begin
                    ir_arg      <= 8'h00;
                    instr_valid <= 1'b1;
                end
            end
            if (accept && state == FETCH_ARG) begin
                ir_arg      <= mem_data;
                instr_valid <= 1'b1;
            end
            if (jump_req || retire)
                instr_valid <= 1'b0;
        end
    end
`ifdef CPU_FETCH_COUNT_EN
    // Count instructions taken by decode, excluding hand-offs cancelled by a redirect
    always_ff @(posedge clk) begin
        if (reset)
            instr_count <= 16'h0000;
        else if (instr_valid && instr_ready && !jump_req)
            instr_count <= instr_count + 16'h0001;
    end
`endif
endmodule

// File: tb/tb_cpu_fetch.sv
// tb_cpu_fetch: directed and randomized checks of cpu_fetch against a PC/memory model and instruction-stream reference.
module tb_cpu_fetch;
    logic        clk = 1'b0;
    logic        reset, mem_ready, instr_ready, jump_req;
    logic [7:0]  pc_addr, mem_data, jump_target;
    logic        increment, jumper, mem_req, instr_valid;
    logic [7:0]  jumper_d, mem_addr, ir_op, ir_arg;
`ifdef CPU_FETCH_COUNT_EN
    logic [15:0] instr_count;
`endif
    logic [7:0]  mem [256];
    int          n_checks = 0;
    int          n_errors = 0;

    cpu_fetch dut (
        .clk(clk), .reset(reset), .pc_addr(pc_addr),
        .increment(increment), .jumper(jumper), .jumper_d(jumper_d),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .ir_op(ir_op), .ir_arg(ir_arg),
        .jump_req(jump_req),
`ifdef CPU_FETCH_COUNT_EN
        .jump_target(jump_target), .instr_count(instr_count)
`else
        .jump_target(jump_target)
`endif
    );

    always #5 clk = ~clk;

    // Program counter the fetch stage drives
    always @(posedge clk)
        pc_addr <= reset ? 8'h00 : jumper ? jumper_d : increment ? pc_addr + 8'h01 : pc_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic mr, input logic ir, input logic jr, input logic [7:0] jt);
        reset = r; mem_ready = mr; instr_ready = ir; jump_req = jr; jump_target = jt;
        mem_data = mem[pc_addr];
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int incs, acc, model_count;
        logic stable;
        logic [7:0] model_pc, op, arg;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        pc_addr = 8'h00;
        mem[8'h00] = 8'h12; mem[8'h05] = 8'h85; mem[8'h06] = 8'h3C;
        mem[8'h07] = 8'h90; mem[8'h08] = 8'h11; mem[8'hFF] = 8'hA0;
        drive(1, 1, 1, 0, 0); tick; tick;
        drive(1, 1, 1, 1, 8'h33);
        check("rst_valid", instr_valid, 0); check("rst_op", ir_op, 0); check("rst_arg", ir_arg, 0);
        check("rst_req", mem_req, 0); check("rst_inc", increment, 0);
        check("rst_jmp", jumper, 0); check("rst_jd", jumper_d, 0);
        tick;
        // one-byte instruction, zero wait states
        drive(1, 0, 1, 0, 0); tick;
        drive(0, 1, 1, 0, 0);
        check("t1_req", mem_req, 1); check("t1_addr", mem_addr, 8'h00); check("t1_inc", increment, 1);
        tick;
        drive(0, 0, 1, 0, 0);
        check("t1_valid", instr_valid, 1); check("t1_op", ir_op, 8'h12); check("t1_arg", ir_arg, 0);
        check("t1_pc", pc_addr, 8'h01); check("t1_inc2", increment, 0);
        tick;
        // redirect to 5, then two-byte instruction with 2 wait states per read
        drive(0, 0, 0, 1, 8'h05);
        check("j5_jumper", jumper, 1); check("j5_jd", jumper_d, 8'h05);
        check("j5_inc", increment, 0); check("j5_req", mem_req, 0);
        tick;
        incs = 0;
        for (int i = 0; i < 6; i++) begin
            drive(0, i % 3 == 2, 0, 0, 0);
            check("t2_addr", mem_addr, i < 3 ? 8'h05 : 8'h06);
            incs += increment;
            tick;
        end
        check("t2_incs", incs, 2);
        drive(0, 0, 0, 0, 0);
        check("t2_valid", instr_valid, 1); check("t2_op", ir_op, 8'h85);
        check("t2_arg", ir_arg, 8'h3C); check("t2_pc", pc_addr, 8'h07);
        // decode stalls for 4 cycles; stray mem_ready must be ignored
        stable = 1;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 0, 0);
            if (!(instr_valid && ir_op == 8'h85 && ir_arg == 8'h3C && !mem_req && !increment)) stable = 0;
            tick;
        end
        check("t3_stable", stable, 1);
        drive(0, 0, 1, 0, 0); tick;
        drive(0, 0, 0, 0, 0);
        check("t3_req", mem_req, 1); check("t3_addr", mem_addr, 8'h07); check("t3_valid", instr_valid, 0);
        // jump concurrent with operand data
        drive(0, 1, 0, 0, 0); tick;
        drive(0, 1, 1, 1, 8'h40);
        check("t4_jumper", jumper, 1); check("t4_jd", jumper_d, 8'h40);
        check("t4_inc", increment, 0); check("t4_req", mem_req, 0);
        tick;
        drive(0, 0, 0, 0, 0);
        check("t4_valid", instr_valid, 0); check("t4_addr", mem_addr, 8'h40); check("t4_req2", mem_req, 1);
        check("t4_op", ir_op, 8'h90); check("t4_arg", ir_arg, 8'h3C);
        // two-byte instruction across the 0xFF wrap
        drive(0, 0, 0, 1, 8'hFF); tick;
        drive(0, 1, 0, 0, 0); tick;
        drive(0, 1, 0, 0, 0);
        check("t5_addr", mem_addr, 8'h00);
        tick;
        drive(0, 0, 0, 0, 0);
        check("t5_valid", instr_valid, 1); check("t5_op", ir_op, 8'hA0);
        check("t5_arg", ir_arg, 8'h12); check("t5_pc", pc_addr, 8'h01);
        // reset during an operand wait
        drive(0, 0, 1, 0, 0); tick;
        mem[8'h01] = 8'h81;
        drive(0, 1, 0, 0, 0); tick;
        drive(0, 0, 0, 0, 0); tick;
        drive(1, 0, 0, 0, 0); tick;
        drive(0, 0, 0, 0, 0);
        check("t6_valid", instr_valid, 0); check("t6_op", ir_op, 0); check("t6_arg", ir_arg, 0);
        check("t6_addr", mem_addr, 8'h00); check("t6_req", mem_req, 1);
        // three accepted instructions, then reset clears the count
        acc = 0;
        for (int i = 0; i < 40 && acc < 3; i++) begin
            drive(0, 1, 1, 0, 0);
            if (instr_valid) acc++;
            tick;
        end
        check("t7_acc", acc, 3);
`ifdef CPU_FETCH_COUNT_EN
        check("t7_count3", instr_count, 3);
        drive(1, 0, 0, 0, 0); tick;
        check("t7_count0", instr_count, 0);
`endif
        // randomized run against the instruction-stream model
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        drive(1, 0, 0, 0, 0); tick;
        model_pc = 8'h00; model_count = 0;
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(199) == 0, $urandom_range(1), $urandom_range(3) != 0,
                  $urandom_range(15) == 0, 8'($urandom));
            check("r_excl", increment & jumper, 0);
`ifdef CPU_FETCH_COUNT_EN
            check("r_count", instr_count, 16'(model_count));
`endif
            if (reset) begin
                check("r_rst_req", mem_req, 0); check("r_rst_inc", increment, 0); check("r_rst_jmp", jumper, 0);
                model_pc = 8'h00; model_count = 0;
            end else if (jump_req) begin
                check("r_jmp", jumper, 1); check("r_jd", jumper_d, jump_target);
                check("r_jreq", mem_req, 0); check("r_jinc", increment, 0);
                model_pc = jump_target;
            end else begin
                check("r_nojmp", {jumper, jumper_d}, 0);
                check("r_req", mem_req, !instr_valid);
                check("r_inc", increment, mem_req & mem_ready);
                if (instr_valid && instr_ready) begin
                    op  = mem[model_pc];
                    arg = op[7] ? mem[8'(model_pc + 8'h01)] : 8'h00;
                    check("r_op", ir_op, op); check("r_arg", ir_arg, arg);
                    model_pc = model_pc + (op[7] ? 8'h02 : 8'h01);
                    model_count = (model_count + 1) % 65536;
                end
            end
            tick;
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
